// File: rtl/firebird7_in_gate2_tessent_tdr_ctrl.sv
// IJTAG test data register downstream of the gate2 SIB: captures sticky instrument
// status, shifts a DATA_WIDTH-bit chain, and hands updated control words to the instrument.
module firebird7_in_gate2_tessent_tdr_ctrl #(
    parameter int                    DATA_WIDTH   = 16,
    parameter int                    STATUS_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0
) (
    input  logic                    ijtag_tck,
    input  logic                    ijtag_reset,
    input  logic                    ijtag_sel,
    input  logic                    ijtag_si,
    input  logic                    ijtag_ce,
    input  logic                    ijtag_se,
    input  logic                    ijtag_ue,
    output logic                    ijtag_so,
    input  logic [STATUS_WIDTH-1:0] status_in,
    output logic [DATA_WIDTH-1:0]   ctrl_data,
    output logic                    ctrl_valid,
    input  logic                    ctrl_ack
);

    logic [DATA_WIDTH-1:0]   shift_reg;
    logic [DATA_WIDTH-1:0]   upd_reg;
    logic [STATUS_WIDTH-1:0] sticky;
    logic                    valid;
    logic                    overrun;
    logic [DATA_WIDTH-1:0]   capture_word;
    logic                    do_capture;
    logic                    do_shift;
    logic                    do_update;

    // Enables are mutually exclusive after priority resolution: capture > shift > update.
    always_comb begin
        do_capture = ijtag_sel & ijtag_ce;
        do_shift   = ijtag_sel & ijtag_se & ~ijtag_ce;
        do_update  = ijtag_sel & ijtag_ue & ~ijtag_ce & ~ijtag_se;
    end

    generate
        if (DATA_WIDTH > STATUS_WIDTH + 2) begin : g_wide
            assign capture_word = {upd_reg[DATA_WIDTH-1:STATUS_WIDTH+2], overrun, valid, sticky};
        end else begin : g_narrow
            assign capture_word = {overrun, valid, sticky};
        end
    endgenerate

    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            shift_reg <= '0;
            upd_reg   <= RESET_VALUE;
            sticky    <= '0;
            valid     <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (do_capture) begin
                shift_reg <= capture_word;
            end else if (do_shift) begin
                shift_reg <= {ijtag_si, shift_reg[DATA_WIDTH-1:1]};
            end

            if (do_update) begin
                upd_reg <= shift_reg;
            end

            // Reload rather than clear on capture so an event arriving that cycle survives.
            sticky <= do_capture ? status_in : (sticky | status_in);

            // An update coinciding with ack refills the slot, so it is not an overrun.
            if (do_update) begin
                valid <= 1'b1;
            end else if (ctrl_ack) begin
                valid <= 1'b0;
            end

            if (do_capture) begin
                overrun <= 1'b0;
            end else if (do_update && valid && !ctrl_ack) begin
                overrun <= 1'b1;
            end
        end
    end

    assign ijtag_so   = shift_reg[0];
    assign ctrl_data  = upd_reg;
    assign ctrl_valid = valid;

endmodule

// File: tb/tb_firebird7_in_gate2_tessent_tdr_ctrl.sv
// Bench for the gate2 TDR: directed scenarios plus randomized traffic against a
// queue-based behavioural model of the register.
module tb_firebird7_in_gate2_tessent_tdr_ctrl;

    logic        clk = 1'b0;
    logic        rst, sel, si, ce, se, ue, ack;
    logic        so;
    logic [7:0]  status;
    logic [15:0] data;
    logic        valid;

    int checks   = 0;
    int failures = 0;

    // Model: scan chain as a bit queue (front = bit 0 = scan out).
    logic        mq[$];
    logic [15:0] m_upd;
    logic [7:0]  m_sticky;
    logic        m_val, m_ovr;

    firebird7_in_gate2_tessent_tdr_ctrl #(
        .DATA_WIDTH(16), .STATUS_WIDTH(8), .RESET_VALUE(16'h0000)
    ) dut (
        .ijtag_tck(clk), .ijtag_reset(rst), .ijtag_sel(sel), .ijtag_si(si),
        .ijtag_ce(ce), .ijtag_se(se), .ijtag_ue(ue), .ijtag_so(so),
        .status_in(status), .ctrl_data(data), .ctrl_valid(valid), .ctrl_ack(ack)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] chain_word();
        logic [15:0] w;
        for (int i = 0; i < 16; i++) w[i] = mq[i];
        return w;
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, settle 1ns after it.
    task automatic step(input logic r, input logic s, input logic c, input logic sh,
                        input logic u, input logic d, input logic a, input logic [7:0] st);
        logic        cap, shf, upd, n_val, n_ovr;
        logic [15:0] w;
        rst = r; sel = s; ce = c; se = sh; ue = u; si = d; ack = a; status = st;
        cap = s & c;
        shf = s & sh & ~c;
        upd = s & u & ~c & ~sh;
        @(posedge clk);
        if (r) begin
            mq = {};
            for (int i = 0; i < 16; i++) mq.push_back(1'b0);
            m_upd = 16'h0000; m_sticky = '0; m_val = 0; m_ovr = 0;
        end else begin
            n_val = upd ? 1'b1 : (a ? 1'b0 : m_val);
            n_ovr = cap ? 1'b0 : ((upd && m_val && !a) ? 1'b1 : m_ovr);
            if (upd) m_upd = chain_word();
            if (cap) begin
                w  = {m_upd[15:10], m_ovr, m_val, m_sticky};
                mq = {};
                for (int i = 0; i < 16; i++) mq.push_back(w[i]);
            end else if (shf) begin
                void'(mq.pop_front());
                mq.push_back(d);
            end
            m_sticky = cap ? st : (m_sticky | st);
            m_val = n_val;
            m_ovr = n_ovr;
        end
        #1;
    endtask

    task automatic unload(output logic [15:0] w);
        for (int i = 0; i < 16; i++) begin
            w[i] = so;
            step(0, 1, 0, 1, 0, 0, 0, 8'h00);
        end
    endtask

    task automatic capture_read(input logic [7:0] st_cap, output logic [15:0] w);
        step(0, 1, 1, 0, 0, 0, 0, st_cap);
        unload(w);
    endtask

    task automatic shift_in(input logic [15:0] v);
        for (int i = 0; i < 16; i++) step(0, 1, 0, 1, 0, v[i], 0, 8'h00);
    endtask

    task automatic test_reset();
        logic [15:0] w;
        for (int i = 0; i < 5; i++) step(0, 1, 0, 1, 0, 1'($urandom), 0, 8'h00);
        step(1, 1, 0, 1, 0, 1, 0, 8'h00);
        step(1, 1, 0, 1, 0, 1, 0, 8'h00);
        checks++; if (so !== 1'b0) begin failures++; $display("FAIL reset_so got=%0b exp=0", so); end
        checks++; if (data !== 16'h0000) begin failures++; $display("FAIL reset_data got=%h exp=0000", data); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", valid); end
        capture_read(8'h00, w);
        checks++; if (w !== 16'h0000) begin failures++; $display("FAIL reset_capture got=%h exp=0000", w); end
    endtask

    task automatic test_shift_update();
        logic [15:0] w;
        shift_in(16'hA5C3);
        checks++; if (valid !== 1'b0 || data !== 16'h0000) begin
            failures++; $display("FAIL pre_update got=%h/%0b exp=0000/0", data, valid); end
        step(0, 1, 0, 0, 1, 0, 0, 8'h00);
        checks++; if (data !== 16'hA5C3) begin failures++; $display("FAIL update_data got=%h exp=a5c3", data); end
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL update_valid got=%0b exp=1", valid); end
        unload(w);
        checks++; if (w !== 16'hA5C3) begin failures++; $display("FAIL shift_out got=%h exp=a5c3", w); end
        checks++; if (data !== 16'hA5C3) begin failures++; $display("FAIL data_hold_shift got=%h exp=a5c3", data); end
    endtask

    task automatic test_handshake();
        logic [15:0] w;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 0, 0, 0, 8'h00);
            checks++; if (valid !== 1'b1) begin failures++; $display("FAIL hold_valid cyc=%0d got=%0b exp=1", i, valid); end
        end
        step(0, 0, 0, 0, 0, 0, 1, 8'h00);
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL ack_valid got=%0b exp=0", valid); end
        step(0, 1, 0, 0, 1, 0, 0, 8'h00);
        step(0, 1, 0, 0, 1, 0, 0, 8'h00);
        capture_read(8'h00, w);
        checks++; if (w[9] !== 1'b1) begin failures++; $display("FAIL overrun_set got=%0b exp=1", w[9]); end
        checks++; if (w[8] !== 1'b1) begin failures++; $display("FAIL overrun_valid got=%0b exp=1", w[8]); end
        capture_read(8'h00, w);
        checks++; if (w[9] !== 1'b0) begin failures++; $display("FAIL overrun_clear got=%0b exp=0", w[9]); end
        // Update with ack in the same cycle: refilled, no overrun.
        step(0, 1, 0, 0, 1, 0, 1, 8'h00);
        capture_read(8'h00, w);
        checks++; if (w[9:8] !== 2'b01) begin failures++; $display("FAIL upd_ack got=%b exp=01", w[9:8]); end
    endtask

    task automatic test_sticky();
        logic [15:0] w;
        step(0, 0, 0, 0, 0, 0, 0, 8'h81);
        capture_read(8'h00, w);
        checks++; if (w[7:0] !== 8'h81) begin failures++; $display("FAIL sticky_set got=%h exp=81", w[7:0]); end
        capture_read(8'h00, w);
        checks++; if (w[7:0] !== 8'h00) begin failures++; $display("FAIL sticky_clear got=%h exp=00", w[7:0]); end
        capture_read(8'h04, w);
        checks++; if (w[7:0] !== 8'h00) begin failures++; $display("FAIL sticky_capcyc_old got=%h exp=00", w[7:0]); end
        capture_read(8'h00, w);
        checks++; if (w[7:0] !== 8'h04) begin failures++; $display("FAIL sticky_capcyc_new got=%h exp=04", w[7:0]); end
    endtask

    task automatic test_select_gating();
        logic [15:0] w, d0;
        logic        v0;
        shift_in(16'h3C5A);
        d0 = data; v0 = valid;
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0, 8'h00);
            checks++; if (so !== 1'b0 || data !== d0 || valid !== v0) begin
                failures++; $display("FAIL unsel_hold cyc=%0d got=%0b/%h/%0b exp=0/%h/%0b", i, so, data, valid, d0, v0); end
        end
        unload(w);
        checks++; if (w !== 16'h3C5A) begin failures++; $display("FAIL unsel_chain got=%h exp=3c5a", w); end
    endtask

    task automatic test_priority();
        logic [15:0] w, exp_w, d0;
        logic        b1;
        step(0, 0, 0, 0, 0, 0, 1, 8'h00);
        shift_in(16'hFFFF);
        exp_w = {m_upd[15:10], m_ovr, m_val, m_sticky};
        step(0, 1, 1, 1, 0, 1, 0, 8'h00);
        unload(w);
        checks++; if (w !== exp_w) begin failures++; $display("FAIL ce_se_capture got=%h exp=%h", w, exp_w); end
        shift_in(16'h0002);
        d0 = data; b1 = 1'b1;
        step(0, 1, 0, 1, 1, 1, 0, 8'h00);
        checks++; if (valid !== 1'b0 || data !== d0) begin
            failures++; $display("FAIL se_ue_no_update got=%0b/%h exp=0/%h", valid, data, d0); end
        checks++; if (so !== b1) begin failures++; $display("FAIL se_ue_shift got=%0b exp=%0b", so, b1); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0),
                 1'($urandom), ($urandom_range(0, 4) == 0), 1'($urandom), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00);
            checks++; if (so !== mq[0] || data !== m_upd || valid !== m_val) begin
                failures++; $display("FAIL random cyc=%0d got=%0b/%h/%0b exp=%0b/%h/%0b",
                                     i, so, data, valid, mq[0], m_upd, m_val); end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mq.push_back(1'b0);
        m_upd = '0; m_sticky = '0; m_val = 0; m_ovr = 0;
        step(1, 0, 0, 0, 0, 0, 0, 8'h00);
        test_reset();
        test_shift_update();
        test_handshake();
        test_sticky();
        test_select_gating();
        test_priority();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/firebird7_in_gate2_tessent_tdr_ctrl.md
# firebird7_in_gate2_tessent_tdr_ctrl

Instrument-side IJTAG test data register that sits directly downstream of the gate2 SIB: its scan input and selects come from the SIB's host-side ijtag_si, ijtag_to_sel and ijtag_ce/se/ue. Its scan output drives the SIB's ijtag_from_so. It captures sticky instrument status, shifts a DATA_WIDTH-bit register, and on update presents a control word to the instrument. It holds that word valid under a valid/ack handshake and flags overruns.

## Interface
- DATA_WIDTH, 16, length of shift and update registers; must be ≥ STATUS_WIDTH+2
- STATUS_WIDTH, 8, number of sticky status inputs
- RESET_VALUE, 16'h0000, value of ctrl_data after reset (DATA_WIDTH bits)

- ijtag_tck  in  1  clock; the single clock; all state updates on its rising edge
- ijtag_reset  in  1  reset; synchronous, active-high
- ijtag_sel  in  1  register selected (driven by SIB ijtag_to_sel)
- ijtag_si  in  1  scan in
- ijtag_ce  in  1  capture enable
- ijtag_se  in  1  shift enable
- ijtag_ue  in  1  update enable
- ijtag_so  out  1  scan out, to SIB ijtag_from_so
- status_in  in  STATUS_WIDTH  instrument status, level inputs, sampled every cycle
- ctrl_data  out  DATA_WIDTH  update register contents
- ctrl_valid  out  1  new ctrl_data pending for instrument
- ctrl_ack  in  1  instrument consumed ctrl_data

## Operation
- State: shift_reg[DATA_WIDTH], upd_reg[DATA_WIDTH], sticky[STATUS_WIDTH], valid, overrun.
- Reset (ijtag_reset=1 at a rising edge): shift_reg=0, upd_reg=RESET_VALUE, sticky=0, valid=0, overrun=0. Reset wins over every other event, including mid-shift.
- Ops are gated by ijtag_sel. Priority when several enables are high: ce > se > ue. Unselected means shift_reg holds.
- Capture (ce&sel): shift_reg <= {upd_reg[DATA_WIDTH-1:STATUS_WIDTH+2], overrun, valid, sticky}.
- Shift (se&sel, no ce): shift_reg <= {ijtag_si, shift_reg[DATA_WIDTH-1:1]}. LSB first out. ijtag_so = shift_reg[0] at all times, combinational from the register. Retiming is done by the SIB.
- Update (ue&sel, no ce/se): upd_reg <= shift_reg and valid <= 1. If valid was already 1 and ctrl_ack is not high that cycle, overrun <= 1.
- Handshake: ctrl_valid=valid; ctrl_data=upd_reg. Transfer occurs on a cycle with valid&ctrl_ack, then valid <= 0. When update and ack coincide, the update wins: valid stays 1 and there is no overrun. ctrl_ack with valid=0 is ignored.
- Sticky status: each cycle sticky <= sticky | status_in.
- Clear on capture: on a capture cycle, sticky <= status_in (the captured value was the old sticky) and overrun <= 0. This means no event is lost when it arrives on the capture cycle.
- ctrl_data is unchanged by capture and shift. It changes only on update and reset.

## Timing
- All outputs are registered except ijtag_so, which is a direct register bit.
- ijtag_so presents the new LSB one cycle after each shift edge. A full unload takes DATA_WIDTH shift cycles.
- Update → ctrl_data/ctrl_valid visible 1 cycle later (after the update edge).
- ctrl_ack sampled at the edge: ctrl_valid falls the cycle after the first valid&ack edge.
- status_in pulse of ≥1 cycle → sticky set the next edge; it is visible in the next capture.
- Reset outputs: ijtag_so=0, ctrl_data=RESET_VALUE, ctrl_valid=0.

## Test plan
- Reset: hold ijtag_reset 2 cycles during an active shift → ijtag_so=0, ctrl_data=16'h0000, ctrl_valid=0, and the next capture yields 16'h0000.
- Shift/update: select, shift 16'hA5C3 LSB first, then update → ctrl_data=16'hA5C3, ctrl_valid=1 one cycle after the ue edge. ijtag_so during the next 16 shifts reproduces the bits shifted in.
- Handshake: after the update, hold ctrl_ack low 5 cycles → ctrl_valid stays 1. Pulse ctrl_ack → ctrl_valid=0 next cycle. A second update with no ack between → capture shows overrun=1 (bit 9), and the following capture shows overrun=0.
- Sticky: pulse status_in=8'h81 for 1 cycle, then capture → low byte 8'h81. Recapture with status_in=0 → low byte 8'h00. Drive status_in=8'h04 on the capture cycle itself → that capture reads the old value, the next capture reads 8'h04.
- Select gating: ijtag_sel=0 with ce/se/ue toggled → shift_reg, ctrl_data and ctrl_valid unchanged.
- Priority: assert ce and se together → capture only. Assert se and ue together → shift only, with no ctrl_valid rise.
